// File: rtl/laser_tx_framer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : laser_pkg
// Brief    : Shared types and line-level constants for the laser TX framer.
// Revision : 1.0 - initial release
// ============================================================================
package laser_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_START    = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_PARITY   = 3'd4;
    localparam logic [2:0] ST_STOP     = 3'd5;

    typedef enum logic [2:0] {
        TX_IDLE     = ST_IDLE,
        TX_PREAMBLE = ST_PREAMBLE,
        TX_START    = ST_START,
        TX_DATA     = ST_DATA,
        TX_PARITY   = ST_PARITY,
        TX_STOP     = ST_STOP
    } tx_state_t;

    localparam logic LINE_IDLE      = 1'b1;
    localparam logic START_LVL      = 1'b0;
    localparam logic STOP_LVL       = 1'b1;
    localparam logic PREAMBLE_FIRST = 1'b0;

    // Counter must hold the longest per-state count (16 preamble bits or DATA_W).
    function automatic int cnt_width(input int data_w);
        return $clog2(((data_w > 16) ? data_w : 16) + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/laser_tx_framer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : laser_tx_if
// Brief    : Byte valid/ready handshake into the laser TX framer.
// Revision : 1.0 - initial release
// ============================================================================
interface laser_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input  data_ready);
    modport slave  (input  data_in, input  data_valid, output data_ready);
endinterface
`default_nettype wire

// File: rtl/laser_tx_framer_bit_tick_detect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit_tick_detect
// Brief    : Samples a synchronous bit-rate strobe and emits a one-cycle pulse
//            on each rising edge. Shared with the receive path.
// Revision : 1.0 - initial release
// ============================================================================
module bit_tick_detect (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_bit_clk,
    output logic      o_tick
);
    logic r_bc_q;
    logic r_bc_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bc_q  <= 1'b0;
            r_bc_q2 <= 1'b0;
        end else begin
            r_bc_q  <= i_bit_clk;
            r_bc_q2 <= r_bc_q;
        end
    end

    assign o_tick = r_bc_q & ~r_bc_q2;
endmodule
`default_nettype wire

// File: rtl/laser_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : laser_tx_framer
// Brief    : Byte-to-NRZ framer: [preamble] start, data LSB-first, [parity],
//            stop bit(s). Parity stage built only with LASER_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module laser_tx_framer
    import laser_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int STOP_BITS    = 1,
    parameter int PREAMBLE_LEN = 0
) (
    input  wire logic   CLOCK_50,
    input  wire logic   reset,
    input  wire logic   bit_clk,
    laser_tx_if.slave   s_tx,
    output logic        laser_out,
    output logic        div_en,
    output logic        tx_busy,
    output logic        frame_done
);
    localparam int CNT_W = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] C_PRE_LAST  = CNT_W'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] C_DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] C_STOP_END  = CNT_W'(STOP_BITS);

    tx_state_t         r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_line;
    logic              r_ready;
    logic              r_div_en;
    logic              r_busy;
    logic              r_done;
    logic              w_tick;
`ifdef LASER_TX_PARITY_EN
    logic              r_par;
`endif

    bit_tick_detect u_tick (
        .clk       (CLOCK_50),
        .rst_n     (reset),
        .i_bit_clk (bit_clk),
        .o_tick    (w_tick)
    );

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state  <= TX_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_line   <= LINE_IDLE;
            r_ready  <= 1'b1;
            r_div_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef LASER_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_line <= LINE_IDLE;
                    // Ticks are ignored here, including one landing on the accept cycle.
                    if (s_tx.data_valid && r_ready) begin
                        r_shift  <= s_tx.data_in;
                        r_busy   <= 1'b1;
                        r_div_en <= 1'b1;
                        r_ready  <= 1'b0;
                        r_cnt    <= '0;
`ifdef LASER_TX_PARITY_EN
                        r_par    <= 1'b0;
`endif
                        if (PREAMBLE_LEN > 0) r_state <= TX_PREAMBLE;
                        else                  r_state <= TX_START;
                    end
                end
                TX_PREAMBLE: if (w_tick) begin
                    r_line <= PREAMBLE_FIRST ^ r_cnt[0];
                    if (r_cnt == C_PRE_LAST) begin
                        r_cnt   <= '0;
                        r_state <= TX_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_START: if (w_tick) begin
                    r_line  <= START_LVL;
                    r_cnt   <= '0;
                    r_state <= TX_DATA;
                end
                TX_DATA: if (w_tick) begin
                    r_line  <= r_shift[0];
                    r_shift <= {1'b0, r_shift[DATA_W-1:1]};
`ifdef LASER_TX_PARITY_EN
                    r_par   <= r_par ^ r_shift[0];
`endif
                    if (r_cnt == C_DATA_LAST) begin
                        r_cnt <= '0;
`ifdef LASER_TX_PARITY_EN
                        r_state <= TX_PARITY;
`else
                        r_state <= TX_STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef LASER_TX_PARITY_EN
                TX_PARITY: if (w_tick) begin
                    r_line  <= r_par;
                    r_cnt   <= '0;
                    r_state <= TX_STOP;
                end
`endif
                TX_STOP: if (w_tick) begin
                    // The tick after the last stop bit closes the frame.
                    if (r_cnt == C_STOP_END) begin
                        r_line   <= LINE_IDLE;
                        r_cnt    <= '0;
                        r_state  <= TX_IDLE;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_div_en <= 1'b0;
                        r_ready  <= 1'b1;
                    end else begin
                        r_line <= STOP_LVL;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_line   <= LINE_IDLE;
                    r_cnt    <= '0;
                    r_state  <= TX_IDLE;
                    r_busy   <= 1'b0;
                    r_div_en <= 1'b0;
                    r_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign s_tx.data_ready = r_ready;
    assign laser_out       = r_line;
    assign div_en          = r_div_en;
    assign tx_busy         = r_busy;
    assign frame_done      = r_done;
endmodule
`default_nettype wire

// File: doc/laser_tx_framer.md
Name: laser_tx_framer

Overview:
- Byte-to-serial framer for the laser transmit path. Sits directly downstream of the clock divider: consumes its divided clock `clk_divided` as a bit-rate strobe and drives its `en` input.
- Accepts bytes over a valid/ready handshake and emits a framed NRZ bit stream on the laser driver pin: optional preamble, start bit, data LSB-first, optional parity, stop bit(s).
- Runs entirely in the `CLOCK_50` domain; the divided clock is sampled as data, never used as a clock.

Parameters:
- DATA_W, 8, payload bits per frame
- STOP_BITS, 1, stop bits per frame (1 or 2)
- PREAMBLE_LEN, 0, alternating preamble bits before the start bit; must be even, 0..16

Ports:
- CLOCK_50  input  1  system clock; the only clock
- reset  input  1  asynchronous, active-low reset
- bit_clk  input  1  divided clock from the divider, synchronous to `CLOCK_50`
- data_in  input  DATA_W  byte to transmit; sampled only on handshake
- data_valid  input  1  upstream has a byte
- data_ready  output  1  framer can accept a byte
- laser_out  output  1  serial line to the laser driver; idle level is 1
- div_en  output  1  enable to the divider
- tx_busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- **Reset values (async, while reset=0):** laser_out=1, data_ready=1, div_en=0, tx_busy=0, frame_done=0, state=IDLE, counters=0. A reset mid-frame drops the frame immediately; there is no partial completion.
- **Tick generation:** bit_clk is registered once (bc_q); tick = bc_q & ~bc_q2. A tick is therefore seen 2 cycles after a bit_clk rising edge. laser_out is registered and updates in the cycle after the tick.
- **States:** IDLE, PREAMBLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - data_ready=1, div_en=0, laser_out=1; ticks are ignored.
  - On data_valid & data_ready: latch data_in into the shift register, set tx_busy=1 and div_en=1, deassert data_ready the next cycle, and go to PREAMBLE (or START if PREAMBLE_LEN=0).
  - laser_out stays 1 until the first tick.
- **PREAMBLE:** each tick drives the next bit of the pattern 0,1,0,1,…; after PREAMBLE_LEN ticks, go to START.
- **START:** the tick drives 0; go to DATA.
- **DATA:** each tick drives shift_reg[0] and shifts right; after DATA_W ticks, go to PARITY (if enabled) or STOP.
- **STOP:** each tick drives 1. After STOP_BITS stop ticks, the next tick ends the frame:
  - state=IDLE, frame_done=1 for one cycle, tx_busy=0, div_en=0, data_ready=1 in the same cycle.
- **Frame length:** PREAMBLE_LEN + 1 + DATA_W + (PARITY ? 1 : 0) + STOP_BITS bit periods, plus one closing tick.
- **Back-to-back frames:** a byte presented during the frame_done cycle is accepted that cycle (data_ready=1).
- **Handshake:**
  - data_valid may drop before acceptance without effect.
  - data_in changes after acceptance do not affect the frame.
  - data_ready is never high while tx_busy=1.
- **Bit counter:** sized `$clog2(max(16, DATA_W)+1)`; cleared on each state change; no wrap occurs within a state.
- **bit_clk held high on entry:** the divider clears it when disabled, so no false tick at frame start. If a tick coincides with the accept cycle, it is ignored.

Optional Feature:
- Macro: LASER_TX_PARITY_EN.
- **Defined:** the PARITY state is inserted after DATA; its tick drives even parity (XOR of the latched byte).
- **Undefined:** no PARITY state; DATA goes directly to STOP; no parity logic is synthesized.

Decomposition:
- Package `laser_pkg`:
  - `tx_state_t` enum.
  - Constants LINE_IDLE=1'b1, START_LVL=1'b0, STOP_LVL=1'b1, PREAMBLE_FIRST=1'b0.
- Sub-module `bit_tick_detect`: bit_clk register plus rising-edge pulse, reusable by the receiver.

Test Plan:
- **Reset:** assert reset mid-idle → laser_out=1, data_ready=1, div_en=0, tx_busy=0, frame_done=0.
- **Basic frame:** bench drives bit_clk with period 8 cycles; PREAMBLE_LEN=0, STOP_BITS=1, send 0xA5 → laser_out per tick 0,1,0,1,0,0,1,0,1,1; frame_done on tick 11; div_en high from accept to frame_done.
- **Back-to-back:** data_valid held high with 0x00 then 0xFF → data_ready low throughout frame 1; 0xFF accepted in the frame_done cycle; line 0,0×8,1 then 0,1×8,1.
- **Preamble and two stops:** PREAMBLE_LEN=4, STOP_BITS=2, send 0x3C → 0,1,0,1,0,0,0,1,1,1,1,0,0,1,1; 16 ticks to frame_done.
- **Reset mid-frame:** pulse reset low during data bit 3 → laser_out=1 asynchronously, no frame_done; next byte 0x81 produces a clean full frame.
- **Parity (LASER_TX_PARITY_EN defined):** send 0x07 → parity bit 1 between data bit 7 and stop. Send 0x03 → parity bit 0.
